fifo2_arbiter: RTL and testbench
================================

# fifo2_arbiter

Two-requester front end for the `fifo2` byte-to-word packer. It shares fifo2's single 8-bit input port between two byte producers and grants ownership for whole byte pairs, so that every 16-bit word out of fifo2 holds bytes from one producer only. It keeps an owner-tag queue in step with fifo2's word stream and presents each output word with the index of the requester that produced it. It sits between the producers and `fifo2`, and wraps fifo2's output handshake.

## Interface
Parameters:
- `OWNER_DEPTH`, default 4: entries in the owner-tag queue. Must be ≥ fifo2 word capacity; a power of two.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `req0_valid`  in  1  requester 0 has a byte
- `req0_enable`  out  1  requester 0 byte accepted this cycle
- `req0_data`  in  8  requester 0 byte
- `req1_valid`, `req1_enable`, `req1_data`  in/out/in  1/1/8  same for requester 1
- `fifo_input_valid`  out  1  to fifo2 `input_valid`
- `fifo_input_enable`  in  1  from fifo2 `input_enable`
- `fifo_data_in`  out  8  to fifo2 `data_in`
- `fifo_output_valid`  in  1  from fifo2 `output_valid`
- `fifo_output_enable`  out  1  to fifo2 `output_enable`
- `fifo_data_out`  in  16  from fifo2 `data_out`
- `out_valid`  out  1  word available to consumer
- `out_enable`  in  1  consumer accepts word
- `out_data`  out  16  word (= `fifo_data_out`)
- `out_owner`  out  1  requester index of `out_data`

## Operation
- Transfer rule (all ports): a transfer occurs on a rising edge where valid and enable are both 1.
- Registered state: `state` ∈ {IDLE, BYTE0, BYTE1}, `grant` (1 bit), `last_grant` (1 bit), owner queue (`OWNER_DEPTH`×1 bit, read/write pointers, count).
- IDLE: if the owner queue is not full and any `reqN_valid` = 1, pick a winner. If both are valid, the winner is `~last_grant`; otherwise the valid one wins. Then `grant` ← winner and `state` ← BYTE0. Otherwise stay in IDLE.
- BYTE0/BYTE1 input mux (combinational):
  - `fifo_input_valid` = `req[grant]_valid`.
  - `fifo_data_in` = `req[grant]_data`.
  - `req[grant]_enable` = `fifo_input_enable`.
  - The other requester's enable is 0.
- In IDLE, `fifo_input_valid` = 0, both `reqN_enable` = 0, and `fifo_data_in` = 0.
- BYTE0 → BYTE1 on an input transfer.
- BYTE1 → IDLE on an input transfer. On the same edge, push `grant` into the owner queue and set `last_grant` ← `grant`.
- Grant is locked for the full pair. If the granted requester drops valid mid-pair, the arbiter waits and the other requester is not served.
- Output side:
  - `out_valid` = `fifo_output_valid` & (count ≠ 0).
  - `fifo_output_enable` = `out_enable` & (count ≠ 0).
  - `out_data` = `fifo_data_out`.
  - `out_owner` = the queue head, or 0 when the queue is empty.
  - Pop the queue on an output transfer.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo `OWNER_DEPTH`.
- Full is defined as count = `OWNER_DEPTH`. When full, IDLE holds and no new grant is issued. A pair already in progress always completes.

## Timing
- Reset values: `state`=IDLE, `grant`=0, `last_grant`=1 (requester 0 wins the first tie), queue empty. Consequently all outputs reset to 0: `req0_enable`, `req1_enable`, `fifo_input_valid`, `fifo_data_in`, `fifo_output_enable`, `out_valid`, `out_owner`. `out_data` follows `fifo_data_out`.
- Arbitration latency: one cycle in IDLE. The earliest first-byte transfer is on the second edge after valid is seen.
- Each pair costs ≥ 3 cycles (IDLE, BYTE0, BYTE1). There is no back-to-back bypass.
- The input mux and the output handshake are combinational: zero added latency.
- Reset asserted mid-pair: returns to IDLE immediately and drops the partial pair and all tags. fifo2 shares `rstn`, so its state is cleared in the same way.

## Test plan
- Only req0 is valid and sends 0x11, 0x22, 0x33, 0x44 with fifo2 always enabled, then the consumer drains. Expected: two words out, `out_owner` = 0, 0, and `req1_enable` never 1.
- req0 and req1 are both valid continuously (req0 sends 0xA0.., req1 sends 0xB0..). Expected: pair grants in the order 0, 1, 0, 1, and each word contains only A-bytes or only B-bytes, matching `out_owner`.
- req0 is granted, transfers one byte, then drops valid for 5 cycles while req1 is valid. Expected: `req1_enable` stays 0 and `state` stays BYTE1; once req0 resumes its byte completes the pair, and req1 is granted next.
- `out_enable` = 0 with both requesters valid. Expected: exactly `OWNER_DEPTH` pairs accepted, then IDLE holds. Raising `out_enable` for one transfer allows exactly one more grant.
- Queue holds 2 tags while a BYTE1 transfer and an output transfer land on the same edge. Expected: count stays 2 and tag order is preserved.
- `rstn` pulsed low during BYTE1. Expected: all outputs 0 asynchronously, and after release the first tie goes to req0.

Source files
------------

// File: rtl/fifo2_arbiter.sv
// fifo2_arbiter
// Two-requester front end for the fifo2 byte-to-word packer. Ownership of the
// shared byte port is granted for a whole byte pair, so every 16-bit word that
// fifo2 produces holds bytes from a single requester. An owner-tag queue runs
// in step with fifo2's word stream and labels each word with its requester.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no pair in progress; arbitrate when a requester is valid and
//       | the owner queue has room
// BYTE0 | pair granted, waiting for the first byte transfer
// BYTE1 | first byte taken, waiting for the second; tag pushed on transfer

module fifo2_arbiter #(
    parameter int OWNER_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        req0_valid,
    output logic        req0_enable,
    input  logic [7:0]  req0_data,

    input  logic        req1_valid,
    output logic        req1_enable,
    input  logic [7:0]  req1_data,

    output logic        fifo_input_valid,
    input  logic        fifo_input_enable,
    output logic [7:0]  fifo_data_in,

    input  logic        fifo_output_valid,
    output logic        fifo_output_enable,
    input  logic [15:0] fifo_data_out,

    output logic        out_valid,
    input  logic        out_enable,
    output logic [15:0] out_data,
    output logic        out_owner
);

    localparam int PTR_W = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
    localparam int CNT_W = $clog2(OWNER_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OWNER_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OWNER_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic grant;
    logic grant_nxt;
    logic last_grant;
    logic last_grant_nxt;

    // Owner-tag queue: one bit per word held in fifo2.
    logic [OWNER_DEPTH-1:0] tag_q;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic       q_empty;
    logic       q_full;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       in_xfer;
    logic       out_xfer;
    logic       tag_push;
    logic       tag_pop;

    assign q_empty = (count == '0);
    assign q_full  = (count == DEPTH_C);

    // Granted requester as seen through the input mux.
    assign sel_valid = grant ? req1_valid : req0_valid;
    assign sel_data  = grant ? req1_data  : req0_data;

    assign in_xfer  = (state != IDLE) && sel_valid && fifo_input_enable;
    assign tag_push = in_xfer && (state == BYTE1);

    // Output handshake is gated by the tag queue so a word is never presented
    // without its owner; the two streams stay in lock step.
    assign out_valid          = fifo_output_valid && !q_empty;
    assign fifo_output_enable = out_enable && !q_empty;
    assign out_data           = fifo_data_out;
    assign out_owner          = q_empty ? 1'b0 : tag_q[rd_ptr];
    assign out_xfer           = out_valid && out_enable;
    assign tag_pop            = out_xfer;

    // FSM state, grant and round-robin history registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic, arbitration and the byte input mux.
    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        last_grant_nxt   = last_grant;
        fifo_input_valid = 1'b0;
        fifo_data_in     = 8'h00;
        req0_enable      = 1'b0;
        req1_enable      = 1'b0;

        case (state)
            IDLE: begin
                // A full tag queue blocks new grants; fifo2 is full as well.
                if (!q_full && (req0_valid || req1_valid)) begin
                    if (req0_valid && req1_valid) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = req1_valid;
                    end
                    state_nxt = BYTE0;
                end
            end

            BYTE0, BYTE1: begin
                fifo_input_valid = sel_valid;
                fifo_data_in     = sel_data;
                if (grant) begin
                    req1_enable = fifo_input_enable;
                end else begin
                    req0_enable = fifo_input_enable;
                end

                // Grant stays locked until the pair completes, even if the
                // owner stalls and the other requester is waiting.
                if (in_xfer) begin
                    if (state == BYTE0) begin
                        state_nxt = BYTE1;
                    end else begin
                        state_nxt      = IDLE;
                        last_grant_nxt = grant;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Owner-tag queue storage and pointers; push on pair completion, pop on
    // each output word transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (tag_push) begin
                tag_q[wr_ptr] <= grant;
                wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (tag_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Tag occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else begin
            case ({tag_push, tag_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo2_arbiter.sv
// Testbench for fifo2_arbiter with a behavioural fifo2 packer (4 words,
// first byte in the low half) behind it. Expected words go into a scoreboard
// queue when stimulus is issued; a monitor compares on every output transfer.
module tb_fifo2_arbiter;

    localparam int DEPTH = 4;
    localparam int CAP   = 4;

    logic        clk;
    logic        rstn;
    logic        req0_valid, req0_enable;
    logic [7:0]  req0_data;
    logic        req1_valid, req1_enable;
    logic [7:0]  req1_data;
    logic        fifo_input_valid, fifo_input_enable;
    logic [7:0]  fifo_data_in;
    logic        fifo_output_valid, fifo_output_enable;
    logic [15:0] fifo_data_out;
    logic        out_valid, out_enable;
    logic [15:0] out_data;
    logic        out_owner;

    fifo2_arbiter #(.OWNER_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .req0_valid         (req0_valid),
        .req0_enable        (req0_enable),
        .req0_data          (req0_data),
        .req1_valid         (req1_valid),
        .req1_enable        (req1_enable),
        .req1_data          (req1_data),
        .fifo_input_valid   (fifo_input_valid),
        .fifo_input_enable  (fifo_input_enable),
        .fifo_data_in       (fifo_data_in),
        .fifo_output_valid  (fifo_output_valid),
        .fifo_output_enable (fifo_output_enable),
        .fifo_data_out      (fifo_data_out),
        .out_valid          (out_valid),
        .out_enable         (out_enable),
        .out_data           (out_data),
        .out_owner          (out_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fifo2: packs byte pairs into words, low byte first.
    logic [15:0] fmem [CAP];
    logic [1:0]  frd, fwr;
    logic [2:0]  fcnt;
    logic [7:0]  flo;
    logic        fhave;
    logic        f_in_x, f_out_x, f_wpush;

    assign fifo_input_enable = (fcnt < 3'(CAP));
    assign fifo_output_valid = (fcnt != 3'd0);
    assign fifo_data_out     = fmem[frd];
    assign f_in_x   = fifo_input_valid && fifo_input_enable;
    assign f_out_x  = fifo_output_valid && fifo_output_enable;
    assign f_wpush  = f_in_x && fhave;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CAP; i++) fmem[i] <= 16'h0000;
            frd <= 2'd0; fwr <= 2'd0; fcnt <= 3'd0; flo <= 8'h00; fhave <= 1'b0;
        end else begin
            if (f_in_x) begin
                if (fhave) begin
                    fmem[fwr] <= {fifo_data_in, flo};
                    fwr       <= fwr + 2'd1;
                    fhave     <= 1'b0;
                end else begin
                    flo   <= fifo_data_in;
                    fhave <= 1'b1;
                end
            end
            if (f_out_x) frd <= frd + 2'd1;
            fcnt <= fcnt + (f_wpush ? 3'd1 : 3'd0) - (f_out_x ? 3'd1 : 3'd0);
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [15:0] w;
        logic        o;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_word(input logic [15:0] w, input logic o);
        exp_t e;
        e.w = w;
        e.o = o;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && out_valid && out_enable) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {15'd0, out_owner, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(e.w));
                    chk("word_owner", 32'(out_owner), 32'(e.o));
                end
            end
        end
    end

    // Producers: byte queues driven once per cycle at the falling edge.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       en0, en1;
    logic       took0, took1;
    logic [1:0] st;
    logic       saw_r1_en;
    int         bytes_taken;

    task automatic step();
        @(negedge clk);
        if (took0 && q0.size() > 0) void'(q0.pop_front());
        if (took1 && q1.size() > 0) void'(q1.pop_front());
        req0_valid = en0 && (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        req1_valid = en1 && (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
        #1;
        took0 = req0_valid && req0_enable;
        took1 = req1_valid && req1_enable;
        if (took0 || took1) bytes_taken++;
        if (req1_enable) saw_r1_en = 1'b1;
        st = dut.state;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        out_enable = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        took0 = 1'b0; took1 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        saw_r1_en = 1'b0;
        bytes_taken = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_enable = 1'b1;
        while (exp_q.size() > 0 && n < 80) begin
            step();
            n++;
        end
        step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        chk({pfx, "_req0_en"}, 32'(req0_enable), 32'd0);
        chk({pfx, "_req1_en"}, 32'(req1_enable), 32'd0);
        chk({pfx, "_fifo_iv"}, 32'(fifo_input_valid), 32'd0);
        chk({pfx, "_fifo_din"}, 32'(fifo_data_in), 32'd0);
        chk({pfx, "_fifo_oe"}, 32'(fifo_output_enable), 32'd0);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({pfx, "_out_owner"}, 32'(out_owner), 32'd0);
    endtask

    initial begin
        int n;
        logic sim_ok;

        // Reset state
        rstn = 1'b0;
        out_enable = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        took0 = 1'b0; took1 = 1'b0;
        #3;
        check_outputs_zero("reset");

        // 1: req0 alone, consumer drains afterwards
        apply_reset();
        q0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        en0 = 1'b1;
        expect_word(16'h2211, 1'b0);
        expect_word(16'h4433, 1'b0);
        for (int i = 0; i < 16; i++) step();
        chk("t1_bytes", 32'(bytes_taken), 32'd4);
        drain("t1_drain");
        chk("t1_req1_en_never", 32'(saw_r1_en), 32'd0);

        // 2: both valid continuously, alternating pair grants
        apply_reset();
        q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        en0 = 1'b1; en1 = 1'b1;
        expect_word(16'hA1A0, 1'b0);
        expect_word(16'hB1B0, 1'b1);
        expect_word(16'hA3A2, 1'b0);
        expect_word(16'hB3B2, 1'b1);
        drain("t2_drain");
        chk("t2_bytes", 32'(bytes_taken), 32'd8);

        // 3: granted requester stalls mid-pair; the other is not served
        apply_reset();
        q0 = '{8'hC0, 8'hC1};
        q1 = '{8'hD0, 8'hD1};
        en0 = 1'b1; en1 = 1'b1;
        out_enable = 1'b1;
        expect_word(16'hC1C0, 1'b0);
        expect_word(16'hD1D0, 1'b1);
        n = 0;
        do begin step(); n++; end while (!took0 && n < 20);
        chk("t3_first_byte_req0", 32'(took0), 32'd1);
        en0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_req1_en_held", 32'(req1_enable), 32'd0);
            chk("t3_state_byte1", 32'(st), 32'd2);
        end
        en0 = 1'b1;
        drain("t3_drain");

        // 4: consumer stalled; exactly DEPTH pairs, then one more per pop
        apply_reset();
        q0 = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
        q1 = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};
        en0 = 1'b1; en1 = 1'b1;
        expect_word(16'hE1E0, 1'b0);
        expect_word(16'hF1F0, 1'b1);
        expect_word(16'hE3E2, 1'b0);
        expect_word(16'hF3F2, 1'b1);
        expect_word(16'hE5E4, 1'b0);
        expect_word(16'hF5F4, 1'b1);
        expect_word(16'hE7E6, 1'b0);
        expect_word(16'hF7F6, 1'b1);
        for (int i = 0; i < 24; i++) step();
        chk("t4_full_bytes", 32'(bytes_taken), 32'd8);
        chk("t4_full_idle", 32'(st), 32'd0);
        chk("t4_full_count", 32'(dut.count), 32'(DEPTH));
        out_enable = 1'b1;
        step();
        out_enable = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("t4_one_more_bytes", 32'(bytes_taken), 32'd10);
        chk("t4_one_more_idle", 32'(st), 32'd0);
        drain("t4_drain");

        // 5: push and pop on the same edge with two tags queued
        apply_reset();
        q0 = '{8'h60, 8'h61, 8'h62, 8'h63};
        q1 = '{8'h70, 8'h71};
        en0 = 1'b1;
        expect_word(16'h6160, 1'b0);
        expect_word(16'h6362, 1'b0);
        expect_word(16'h7170, 1'b1);
        for (int i = 0; i < 12; i++) step();
        chk("t5_pre_count", 32'(dut.count), 32'd2);
        en1 = 1'b1;
        n = 0;
        do begin step(); n++; end while (!(took1 && st == 2'd1) && n < 20);
        out_enable = 1'b1;
        step();
        sim_ok = took1 && out_valid && out_enable && (st == 2'd2);
        chk("t5_simultaneous", 32'(sim_ok), 32'd1);
        out_enable = 1'b0;
        step();
        chk("t5_post_count", 32'(dut.count), 32'd2);
        drain("t5_drain");

        // 6: reset during BYTE1
        apply_reset();
        q0 = '{8'h80, 8'h81};
        q1 = '{8'h90, 8'h91};
        en0 = 1'b1; en1 = 1'b1;
        out_enable = 1'b1;
        n = 0;
        do begin step(); n++; end while (st != 2'd2 && n < 20);
        chk("t6_reached_byte1", 32'(st), 32'd2);
        #1;
        rstn = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        q0.delete(); q1.delete(); exp_q.delete();
        took0 = 1'b0; took1 = 1'b0;
        q0 = '{8'hC5, 8'hC6};
        q1 = '{8'hD5, 8'hD6};
        expect_word(16'hC6C5, 1'b0);
        expect_word(16'hD6D5, 1'b1);
        step();
        rstn = 1'b1;
        n = 0;
        do begin step(); n++; end while (!(took0 || took1) && n < 20);
        chk("t6_first_tie_req0", {30'd0, took1, took0}, 32'd1);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
